// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the HI/LO multiply stage.
//   - state_t     : FSM state encoding (IDLE/CALC/WB)
//   - LAT_DEFAULT : default number of multiplier settle cycles
//   - LAT_MAX     : largest supported settle count
//   - CNT_W       : width of the settle-cycle counter
//   - prod_t      : 64-bit product type
//   - abs32()     : magnitude of a 32-bit operand for MULT/MULTU
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam int LAT_DEFAULT = 1;
  localparam int LAT_MAX     = 8;
  localparam int CNT_W       = $clog2(LAT_MAX) + 1;

  typedef logic [63:0] prod_t;

  // |-2^31| is 0x8000_0000, which still fits as an unsigned 32-bit value.
  function automatic logic [31:0] abs32(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/hilo_mul_unit_multu.sv
// MULTU: existing unsigned 32x32 -> 64 combinational multiplier.
// Ports:
//   clk, reset : present for drop-in compatibility, no internal state
//   a, b       : unsigned 32-bit operands
//   p          : 64-bit unsigned product
module MULTU
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output prod_t       p
);

  // Clock and reset are deliberately unused: the multiplier is purely combinational.
  wire unused_ok = &{1'b0, clk, reset};

  assign p = {32'd0, a} * {32'd0, b};

endmodule

// File: rtl/hilo_mul_unit.sv
// hilo_mul_unit: multi-cycle MULT/MULTU control and architectural HI/LO.
// Operands are reduced to magnitudes at issue, multiplied by MULTU over LAT
// settle cycles, then the 64-bit product is sign-corrected and committed.
// Ports:
//   clk, reset (async, active-low)
//   start, sign, a, b : multiply issue (sampled only in IDLE)
//   mthi, mtlo, wdata : HI/LO moves, honoured only when not busy
//   hi, lo            : architectural HI/LO
//   busy              : multiply in flight (state != IDLE)
//   done              : one-cycle pulse when a new result first shows on hi/lo
//   dbg_state         : current FSM state
// Handshake: the pipeline stalls while busy=1; start/mthi/mtlo are only
// acted on in a cycle where busy=0, and done marks the first cycle in which
// the committed result is visible.
// LAT must lie in 1..LAT_MAX.
module hilo_mul_unit
  import mul_pkg::*;
#(
  parameter int LAT = LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        ma_q, ma_d;
  logic [31:0]        mb_q, mb_d;
  logic               neg_q, neg_d;
  prod_t              prod_q, prod_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               done_q, done_d;
  prod_t              mul_p;

  MULTU u_multu (
    .clk   (clk),
    .reset (reset),
    .a     (ma_q),
    .b     (mb_q),
    .p     (mul_p)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Moves commit even alongside start; WB later overwrites them.
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start) begin
          ma_d    = abs32(a, sign);
          mb_d    = abs32(b, sign);
          neg_d   = sign & (a[31] ^ b[31]);
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == CNT_W'(LAT - 1)) begin
          prod_d  = mul_p;
          state_d = WB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WB: begin
        // Two's-complement negate mod 2^64; a zero product stays zero.
        {hi_d, lo_d} = neg_q ? (~prod_q + 64'd1) : prod_q;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
